// File: rtl/vga_pkg.sv
// Shared timing defaults, derived totals and coordinate type for the raster scan and renderers.
package vga_pkg;

  localparam int unsigned ClkDivDef   = 4;
  localparam int unsigned HVisibleDef = 640;
  localparam int unsigned HFpDef      = 16;
  localparam int unsigned HSyncDef    = 96;
  localparam int unsigned HBpDef      = 48;
  localparam int unsigned VVisibleDef = 480;
  localparam int unsigned VFpDef      = 10;
  localparam int unsigned VSyncDef    = 2;
  localparam int unsigned VBpDef      = 33;
  localparam int unsigned SyncPolDef  = 0;

  localparam int unsigned HTotalDef = HVisibleDef + HFpDef + HSyncDef + HBpDef;
  localparam int unsigned VTotalDef = VVisibleDef + VFpDef + VSyncDef + VBpDef;

  typedef logic [9:0] coord_t;

  // True when lo <= v < hi.
  function automatic logic in_range(coord_t v, int unsigned lo, int unsigned hi);
    return (32'(v) >= lo) && (32'(v) < hi);
  endfunction

endpackage

// File: rtl/pixel_div.sv
// Clock-enable divider producing one pixel_tick every CLK_DIV clocks; holds its count while en is low.
module pixel_div
  import vga_pkg::*;
#(
  parameter int unsigned CLK_DIV = ClkDivDef
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  output logic pixel_tick_o
);

  // Four bits cover the full 1..16 divide range.
  localparam logic [3:0] DivMax = 4'(CLK_DIV - 1);

  logic [3:0] div_q, div_d;

  assign pixel_tick_o = en_i && (div_q == DivMax);

  always_comb begin
    div_d = div_q;
    if (en_i) begin
      div_d = (div_q == DivMax) ? 4'd0 : div_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= 4'd0;
    end else begin
      div_q <= div_d;
    end
  end

endmodule

// File: rtl/vga_scan.sv
// 640x480@60 raster scan: x/y counters, registered sync/video decode and line/frame strobes.
// Optional 8-bit frame counter is built when VGA_SCAN_FRAME_CNT_EN is defined.
module vga_scan
  import vga_pkg::*;
#(
  parameter int unsigned CLK_DIV   = ClkDivDef,
  parameter int unsigned H_VISIBLE = HVisibleDef,
  parameter int unsigned H_FP      = HFpDef,
  parameter int unsigned H_SYNC    = HSyncDef,
  parameter int unsigned H_BP      = HBpDef,
  parameter int unsigned V_VISIBLE = VVisibleDef,
  parameter int unsigned V_FP      = VFpDef,
  parameter int unsigned V_SYNC    = VSyncDef,
  parameter int unsigned V_BP      = VBpDef,
  parameter int unsigned SYNC_POL  = SyncPolDef
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   en,
  output coord_t x,
  output coord_t y,
  output logic   video_on,
  output logic   hsync,
  output logic   vsync,
  output logic   pixel_tick,
  output logic   line_start,
  output logic   frame_start
`ifdef VGA_SCAN_FRAME_CNT_EN
  ,
  output logic [7:0] frame_cnt
`endif
);

  localparam int unsigned HTotal   = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int unsigned VTotal   = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam coord_t      XMax     = coord_t'(HTotal - 1);
  localparam coord_t      YMax     = coord_t'(VTotal - 1);
  localparam int unsigned HSyncLo  = H_VISIBLE + H_FP;
  localparam int unsigned HSyncHi  = HSyncLo + H_SYNC;
  localparam int unsigned VSyncLo  = V_VISIBLE + V_FP;
  localparam int unsigned VSyncHi  = VSyncLo + V_SYNC;
  localparam logic        SyncAct  = SYNC_POL[0];

  logic   tick;
  coord_t x_q, x_d, y_q, y_d;
  logic   video_on_q, video_on_d;
  logic   hsync_q, hsync_d;
  logic   vsync_q, vsync_d;
  logic   line_start_q, line_start_d;
  logic   frame_start_q, frame_start_d;

  pixel_div #(
    .CLK_DIV(CLK_DIV)
  ) u_pixel_div (
    .clk         (clk),
    .rst_n       (rst_n),
    .en_i        (en),
    .pixel_tick_o(tick)
  );

  // Decode from the next coordinate so the registered levels line up with x/y.
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (tick) begin
      if (x_q == XMax) begin
        x_d = '0;
        y_d = (y_q == YMax) ? '0 : y_q + 10'd1;
      end else begin
        x_d = x_q + 10'd1;
      end
    end
    video_on_d    = in_range(x_d, 0, H_VISIBLE) && in_range(y_d, 0, V_VISIBLE);
    hsync_d       = in_range(x_d, HSyncLo, HSyncHi) ? SyncAct : ~SyncAct;
    vsync_d       = in_range(y_d, VSyncLo, VSyncHi) ? SyncAct : ~SyncAct;
    line_start_d  = tick && (x_d == '0);
    frame_start_d = line_start_d && (y_d == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q           <= XMax;
      y_q           <= YMax;
      video_on_q    <= 1'b0;
      hsync_q       <= ~SyncAct;
      vsync_q       <= ~SyncAct;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      x_q           <= x_d;
      y_q           <= y_d;
      video_on_q    <= video_on_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign x           = x_q;
  assign y           = y_q;
  assign video_on    = video_on_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign pixel_tick  = tick;
  // Strobes are masked while the scan is frozen.
  assign line_start  = line_start_q && en;
  assign frame_start = frame_start_q && en;

`ifdef VGA_SCAN_FRAME_CNT_EN
  logic [7:0] frame_cnt_q, frame_cnt_d;

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (frame_start_d) begin
      frame_cnt_d = frame_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt_q <= 8'd0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign frame_cnt = frame_cnt_q;
`endif

endmodule
